// File: rtl/hex_keypad_scanner_pkg.sv
// hex_keypad_pkg: shared definitions for the 4x4 hex keypad scanner and the
// downstream keypad checker.
//   state_t        scanner FSM states
//   N_ROWS/N_COLS  keypad geometry
//   SETTLE_CYCLES  cycles a scan column is held before its rows are sampled
//   COL_ALL        column drive used while waiting for any key
//   lowest_row()   priority encoder, lowest set row bit wins
//   col_onehot()   one-hot column drive for a column index
//   scan_state()   SCAN state that corresponds to a column index
package hex_keypad_pkg;

  localparam int N_ROWS        = 4;
  localparam int N_COLS        = 4;
  localparam int SETTLE_CYCLES = 3;

  localparam logic [N_COLS-1:0] COL_ALL     = 4'b1111;
  localparam logic [1:0]        SETTLE_LAST = 2'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN0,
    ST_SCAN1,
    ST_SCAN2,
    ST_SCAN3,
    ST_DEBOUNCE,
    ST_RELEASE
  } state_t;

  // Scan downwards so the lowest asserted row is the one left standing.
  function automatic logic [1:0] lowest_row(input logic [N_ROWS-1:0] rows);
    logic [1:0] r;
    r = 2'd0;
    for (int i = N_ROWS - 1; i >= 0; i--) begin
      if (rows[i]) r = 2'(i);
    end
    return r;
  endfunction

  function automatic logic [N_COLS-1:0] col_onehot(input logic [1:0] c);
    logic [N_COLS-1:0] v;
    v    = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  function automatic state_t scan_state(input logic [1:0] c);
    state_t s;
    // NOTE: giving a combinational result a value before the case means every
    // path assigns it, so no storage can be inferred even if a branch is missed.
    s = ST_SCAN0;
    case (c)
      2'd1:    s = ST_SCAN1;
      2'd2:    s = ST_SCAN2;
      2'd3:    s = ST_SCAN3;
      default: s = ST_SCAN0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/hex_keypad_scanner_row_sync.sv
// row_sync: two-flop synchronizer for the raw keypad row returns.
//   clk  in   scanner clock
//   rst  in   asynchronous active-low reset, clears both stages to 0
//   d    in   raw row returns, asynchronous to clk
//   q    out  synchronized row returns
module row_sync
  import hex_keypad_pkg::*;
#(
  parameter int WIDTH = N_ROWS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: clocked state uses non-blocking assignments so both stages sample
  // the pre-edge values; with blocking ones d would fall straight through to q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/hex_keypad_scanner.sv
// hex_keypad_scanner: column-scanning front end for the 4x4 hex keypad.
// Waits with all columns driven, scans columns 0..3 when any row returns,
// debounces the found key and emits one valid strobe per accepted press.
// Key k sits at row k/4, column k%4, so code = {row, col}.
//   DEBOUNCE_CYCLES  stable synchronized cycles needed for press and release
//   CNT_W            debounce counter width
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-low reset
//   row    in   raw keypad row returns (active-high)
//   col    out  column drive (active-high), one-hot or all-ones
//   code   out  hex code of the last latched key candidate
//   valid  out  one-cycle strobe per accepted press
module hex_keypad_scanner
  import hex_keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_ROWS-1:0] row,
  output logic [N_COLS-1:0] col,
  output logic [3:0]        code,
  output logic              valid
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [N_ROWS-1:0] row_s;
  state_t            state;
  logic [1:0]        settle_cnt;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        col_idx;
  logic [1:0]        row_idx;

  row_sync #(.WIDTH(N_ROWS)) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d   (row),
    .q   (row_s)
  );

  // The column drive is registered alongside the state so a new column starts
  // on the same edge as its SCAN state; the settle count then covers the two
  // synchronizer stages before row_s reflects that column.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      col        <= COL_ALL;
      code       <= 4'h0;
      valid      <= 1'b0;
      settle_cnt <= 2'd0;
      cnt        <= '0;
      col_idx    <= 2'd0;
      row_idx    <= 2'd0;
    end else begin
      valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          col <= COL_ALL;
          if (|row_s) begin
            state      <= ST_SCAN0;
            col        <= col_onehot(2'd0);
            col_idx    <= 2'd0;
            settle_cnt <= 2'd0;
          end
        end

        ST_SCAN0, ST_SCAN1, ST_SCAN2, ST_SCAN3: begin
          if (settle_cnt != SETTLE_LAST) begin
            settle_cnt <= settle_cnt + 2'd1;
          end else begin
            settle_cnt <= 2'd0;
            if (|row_s) begin
              // Lowest column wins by scan order, lowest row by the encoder.
              row_idx <= lowest_row(row_s);
              code    <= {lowest_row(row_s), col_idx};
              cnt     <= '0;
              state   <= ST_DEBOUNCE;
            end else if (col_idx == 2'(N_COLS - 1)) begin
              state <= ST_IDLE;
              col   <= COL_ALL;
            end else begin
              col_idx <= col_idx + 2'd1;
              col     <= col_onehot(col_idx + 2'd1);
              state   <= scan_state(col_idx + 2'd1);
            end
          end
        end

        ST_DEBOUNCE: begin
          if (!row_s[row_idx]) begin
            state <= ST_IDLE;
            col   <= COL_ALL;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            // This cycle is the DEBOUNCE_CYCLES-th stable one.
            valid <= 1'b1;
            cnt   <= '0;
            state <= ST_RELEASE;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_ONE;
          end
        end

        ST_RELEASE: begin
          // Only the latched column is driven, so keys in other columns are
          // invisible until this key is let go.
          if (|row_s) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= ST_IDLE;
            col   <= COL_ALL;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_ONE;
          end
        end

        default: begin
          state <= ST_IDLE;
          col   <= COL_ALL;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Testbench for hex_keypad_scanner with DEBOUNCE_CYCLES = 4. A keypad model
// derives row from the pressed-key mask and the driven columns. Edge indices
// count posedges after a key change applied at a negedge (index 0 is the edge
// where the synchronizer first stage captures the new row value).
module tb_hex_keypad_scanner;

  logic        clk;
  logic        rst;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  code;
  logic        valid;
  logic [15:0] key;

  int total;
  int bad;
  int valid_count;
  int double_valid;
  logic valid_q;

  hex_keypad_scanner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .row   (row),
    .col   (col),
    .code  (code),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad: row[r] = OR over c of (key[4r+c] AND col[c]).
  always_comb begin
    row = 4'b0000;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (key[4*r+c] && col[c]) row[r] = 1'b1;
      end
    end
  end

  // Strobe monitor, sampled mid-cycle.
  initial begin
    valid_count  = 0;
    double_valid = 0;
    valid_q      = 1'b0;
  end
  always @(negedge clk) begin
    if (valid === 1'b1) valid_count++;
    if (valid === 1'b1 && valid_q === 1'b1) double_valid++;
    valid_q = valid;
  end

  // Call at a negedge right after changing key. Returns the edge index at
  // which valid was first seen (or -1), and col as seen after edge 'probe'.
  task automatic wait_valid(input int budget, input int probe,
                            output int idx, output logic [3:0] probe_col);
    idx       = -1;
    probe_col = 4'hx;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == probe) probe_col = col;
      if (valid === 1'b1) begin
        idx = i;
        break;
      end
    end
  endtask

  // Release every key and wait (bounded) until the scanner is back in IDLE.
  task automatic release_all(input string name);
    bit ok;
    key = 16'h0000;
    repeat (3) @(negedge clk);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (col === 4'b1111) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s release: col=%b required 1111 within 40 cycles", name, col);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    key = 16'h0000;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (col !== 4'b1111) begin bad++; $display("FAIL reset_col: got %b required 1111", col); end
    total++;
    if (code !== 4'h0) begin bad++; $display("FAIL reset_code: got %h required 0", code); end
    total++;
    if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b required 0", valid); end
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_key0();
    int idx;
    int vc0;
    logic [3:0] pc;
    @(negedge clk);
    vc0 = valid_count;
    key = 16'h0001;
    wait_valid(60, 0, idx, pc);
    total++;
    if (idx !== 9) begin bad++; $display("FAIL key0_valid_edge: got %0d required 9", idx); end
    total++;
    if (code !== 4'h0) begin bad++; $display("FAIL key0_code: got %h required 0", code); end
    repeat (30) @(negedge clk);
    total++;
    if (valid_count - vc0 !== 1) begin
      bad++; $display("FAIL key0_strobes: got %0d required 1", valid_count - vc0);
    end
    // Release: row_s drops after edge 1, RELEASE counts edges 2..5.
    key = 16'h0000;
    repeat (5) begin @(posedge clk); end
    @(negedge clk);
    total++;
    if (col !== 4'b0001) begin bad++; $display("FAIL key0_release_hold: got %b required 0001", col); end
    @(posedge clk);
    @(negedge clk);
    total++;
    if (col !== 4'b1111) begin bad++; $display("FAIL key0_release_idle: got %b required 1111", col); end
    release_all("key0");
  endtask

  task automatic test_key_f();
    int idx;
    logic [3:0] pc;
    @(negedge clk);
    key = 16'h8000;
    wait_valid(60, 15, idx, pc);
    total++;
    if (idx !== 18) begin bad++; $display("FAIL keyF_valid_edge: got %0d required 18", idx); end
    total++;
    if (code !== 4'hF) begin bad++; $display("FAIL keyF_code: got %h required F", code); end
    total++;
    if (pc !== 4'b1000) begin bad++; $display("FAIL keyF_debounce_col: got %b required 1000", pc); end
    release_all("keyF");
  endtask

  task automatic test_same_column();
    int idx;
    int vc0;
    logic [3:0] pc;
    @(negedge clk);
    vc0 = valid_count;
    key = 16'h0022;
    wait_valid(60, 0, idx, pc);
    total++;
    if (idx !== 12) begin bad++; $display("FAIL keys15_valid_edge: got %0d required 12", idx); end
    total++;
    if (code !== 4'h1) begin bad++; $display("FAIL keys15_code: got %h required 1", code); end
    repeat (20) @(negedge clk);
    total++;
    if (valid_count - vc0 !== 1) begin
      bad++; $display("FAIL keys15_strobes: got %0d required 1", valid_count - vc0);
    end
    release_all("keys15");
  endtask

  task automatic test_bounce();
    int idx;
    int vc0;
    logic [3:0] pc;
    @(negedge clk);
    vc0 = valid_count;
    for (int i = 0; i < 20; i++) begin
      key = (i % 3 != 2) ? 16'h0040 : 16'h0000;
      @(negedge clk);
    end
    release_all("bounce");
    total++;
    if (valid_count - vc0 !== 0) begin
      bad++; $display("FAIL bounce_strobes: got %0d required 0", valid_count - vc0);
    end
    vc0 = valid_count;
    key = 16'h0040;
    wait_valid(60, 0, idx, pc);
    total++;
    if (idx !== 15) begin bad++; $display("FAIL bounce_steady_edge: got %0d required 15", idx); end
    total++;
    if (code !== 4'h6) begin bad++; $display("FAIL bounce_steady_code: got %h required 6", code); end
    repeat (10) @(negedge clk);
    total++;
    if (valid_count - vc0 !== 1) begin
      bad++; $display("FAIL bounce_steady_strobes: got %0d required 1", valid_count - vc0);
    end
    release_all("bounce_steady");
  endtask

  task automatic test_back_to_back();
    int idx;
    int vc0;
    logic [3:0] pc;
    @(negedge clk);
    vc0 = valid_count;
    key = 16'h0200;
    wait_valid(60, 0, idx, pc);
    total++;
    if (idx !== 12) begin bad++; $display("FAIL key9_valid_edge: got %0d required 12", idx); end
    total++;
    if (code !== 4'h9) begin bad++; $display("FAIL key9_code: got %h required 9", code); end
    repeat (88) @(negedge clk);
    key = 16'h0204;
    repeat (30) @(negedge clk);
    total++;
    if (valid_count - vc0 !== 1) begin
      bad++; $display("FAIL key9_key2_strobes: got %0d required 1", valid_count - vc0);
    end
    total++;
    if (code !== 4'h9) begin bad++; $display("FAIL key9_code_hold: got %h required 9", code); end
    release_all("key9_key2");
    vc0 = valid_count;
    key = 16'h0004;
    wait_valid(60, 0, idx, pc);
    total++;
    if (idx !== 15) begin bad++; $display("FAIL key2_valid_edge: got %0d required 15", idx); end
    total++;
    if (code !== 4'h2) begin bad++; $display("FAIL key2_code: got %h required 2", code); end
    repeat (10) @(negedge clk);
    total++;
    if (valid_count - vc0 !== 1) begin
      bad++; $display("FAIL key2_strobes: got %0d required 1", valid_count - vc0);
    end
    release_all("key2");
  endtask

  task automatic test_reset_mid_debounce();
    int idx;
    int vc0;
    logic [3:0] pc;
    @(negedge clk);
    vc0 = valid_count;
    key = 16'h0400;
    // DEBOUNCE entered at edge 11, strobe would be registered at edge 15.
    repeat (13) @(posedge clk);
    #2;
    total++;
    if (col !== 4'b0100) begin bad++; $display("FAIL keyA_debounce_col: got %b required 0100", col); end
    rst = 1'b0;
    #1;
    total++;
    if (col !== 4'b1111) begin bad++; $display("FAIL keyA_reset_col: got %b required 1111", col); end
    total++;
    if (code !== 4'h0) begin bad++; $display("FAIL keyA_reset_code: got %h required 0", code); end
    total++;
    if (valid !== 1'b0) begin bad++; $display("FAIL keyA_reset_valid: got %b required 0", valid); end
    repeat (6) @(negedge clk);
    total++;
    if (valid_count - vc0 !== 0) begin
      bad++; $display("FAIL keyA_reset_strobes: got %0d required 0", valid_count - vc0);
    end
    rst = 1'b1;
    wait_valid(60, 0, idx, pc);
    total++;
    if (idx !== 15) begin bad++; $display("FAIL keyA_after_reset_edge: got %0d required 15", idx); end
    total++;
    if (code !== 4'hA) begin bad++; $display("FAIL keyA_after_reset_code: got %h required A", code); end
    repeat (10) @(negedge clk);
    total++;
    if (valid_count - vc0 !== 1) begin
      bad++; $display("FAIL keyA_after_reset_strobes: got %0d required 1", valid_count - vc0);
    end
    release_all("keyA");
  endtask

  task automatic test_no_double_strobe();
    total++;
    if (double_valid !== 0) begin
      bad++; $display("FAIL valid_consecutive: got %0d double-high cycles required 0", double_valid);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    key   = 16'h0000;
    rst   = 1'b0;
    test_reset();
    test_key0();
    test_key_f();
    test_same_column();
    test_bounce();
    test_back_to_back();
    test_reset_mid_debounce();
    test_no_double_strobe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
